// File: rtl/count_pkg.sv
// Shared definitions for the interval-counter arbiter: FSM state encoding
// and default counter/timeout sizing.
package count_pkg;

  localparam int CW_DEF      = 4;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/count_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request at or above
// rr_ptr, wrapping through index 0.
module rr_select #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     any_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(N_REQ);

  always_comb begin
    // NOTE: every output gets a default before the search loop, so no latch
    // is inferred when no request is pending.
    any_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Shares one start/stop interval counter among N_REQ requesters, sequencing
// clear -> start -> run -> stop for the round-robin winner.
module count_arbiter
  import count_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CW      = CW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CW-1:0]      req_len,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [CW-1:0]            result,
  output logic                     aborted,
  output logic                     timed_out,
  output logic                     ctr_clr,
  output logic                     ctr_start,
  output logic                     ctr_stop,
  input  logic [CW-1:0]            ctr_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e          state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   gid_q;
  logic [CW-1:0]   target_q;
  logic [TW-1:0]   tmo_q;
  logic [CW-1:0]   cap_q;
  logic            cap_abort_q;
  logic            cap_tmo_q;

  logic            any_valid;
  logic [IW-1:0]   sel_idx;

  rr_select #(.N_REQ(N_REQ)) u_rr_select (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .any_valid (any_valid),
    .gnt_idx   (sel_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gid_q       <= '0;
      target_q    <= '0;
      tmo_q       <= '0;
      cap_q       <= '0;
      cap_abort_q <= 1'b0;
      cap_tmo_q   <= 1'b0;
      gnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      result      <= '0;
      aborted     <= 1'b0;
      timed_out   <= 1'b0;
      ctr_clr     <= 1'b0;
      ctr_start   <= 1'b0;
      ctr_stop    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; non-blocking assignments let a
      // later branch override the default within the same clock edge.
      done      <= 1'b0;
      ctr_clr   <= 1'b0;
      ctr_start <= 1'b0;
      ctr_stop  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            gid_q       <= sel_idx;
            target_q    <= req_len[int'(sel_idx)*CW +: CW];
            gnt         <= N_REQ'(1) << sel_idx;
            busy        <= 1'b1;
            ctr_clr     <= 1'b1;
            cap_abort_q <= 1'b0;
            cap_tmo_q   <= 1'b0;
            state_q     <= CLEAR;
          end
        end

        CLEAR: begin
          ctr_start <= 1'b1;
          state_q   <= START;
        end

        START: begin
          tmo_q   <= '0;
          state_q <= RUN;
        end

        RUN: begin
          // Abort outranks match, match outranks timeout; only the winner flags.
          if (!req[gid_q] || ctr_count == target_q || tmo_q == TMO_LAST) begin
            cap_q       <= ctr_count;
            cap_abort_q <= !req[gid_q];
            cap_tmo_q   <= req[gid_q] && ctr_count != target_q;
            ctr_stop    <= 1'b1;
            state_q     <= STOP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        STOP: begin
          done      <= 1'b1;
          done_id   <= gid_q;
          result    <= cap_q;
          aborted   <= cap_abort_q;
          timed_out <= cap_tmo_q;
          state_q   <= DONE;
        end

        DONE: begin
          gnt       <= '0;
          busy      <= 1'b0;
          done_id   <= '0;
          result    <= '0;
          aborted   <= 1'b0;
          timed_out <= 1'b0;
          rr_ptr_q  <= (int'(gid_q) == N_REQ - 1) ? '0 : gid_q + 1'b1;
          state_q   <= IDLE;
        end

        default: begin
          gnt     <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter: a start/stop counter model, a
// scoreboard of expected completions, a vector table and corner sequences.
module tb_count_arbiter;
  import count_pkg::*;

  localparam int N_REQ = 4;
  localparam int CW    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N_REQ-1:0]  req = '0;
  logic [N_REQ*CW-1:0] req_len = '0;
  logic [N_REQ-1:0]  gnt;
  logic              busy, done, aborted, timed_out;
  logic [1:0]        done_id;
  logic [CW-1:0]     result;
  logic              ctr_clr, ctr_start, ctr_stop;
  logic [CW-1:0]     ctr_count;

  int checks = 0;
  int failures = 0;

  count_arbiter #(.N_REQ(N_REQ), .CW(CW), .TIMEOUT(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_len   (req_len),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .result    (result),
    .aborted   (aborted),
    .timed_out (timed_out),
    .ctr_clr   (ctr_clr),
    .ctr_start (ctr_start),
    .ctr_stop  (ctr_stop),
    .ctr_count (ctr_count)
  );

  always #5 clk = ~clk;

  // Counter model sharing the arbiter's reset; freeze holds the count.
  logic          freeze = 1'b0;
  logic          cnt_run;
  logic [CW-1:0] cnt;
  assign ctr_count = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      cnt_run <= 1'b0;
    end else if (ctr_clr) begin
      cnt     <= '0;
      cnt_run <= 1'b0;
    end else begin
      if (ctr_start) cnt_run <= 1'b1;
      if (ctr_stop)  cnt_run <= 1'b0;
      if (cnt_run && !freeze) cnt <= cnt + 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]    id;
    logic [CW-1:0] result;
    logic          ab;
    logic          to;
  } exp_t;

  exp_t sb[$];

  // Scoreboard: every done pops one expectation.
  always @(negedge clk) begin
    if (reset) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_id",   32'(done_id),   32'(e.id));
          check("result",    32'(result),    32'(e.result));
          check("aborted",   32'(aborted),   32'(e.ab));
          check("timed_out", 32'(timed_out), 32'(e.to));
          check("done_gnt",  32'(gnt),       32'(4'b0001 << e.id));
        end
      end
    end
  end

  task automatic set_len(input int id, input int len);
    req_len[id*CW +: CW] = CW'(len);
  endtask

  task automatic push(input int id, input int res, input bit ab, input bit to);
    exp_t e;
    e.id = 2'(id); e.result = CW'(res); e.ab = ab; e.to = to;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_count(input int id, input int val, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (gnt[id] && busy && int'(ctr_count) == val && !ctr_start && !ctr_clr) seen = 1'b1;
    end
    if (!seen) check("count_wait_expired", 32'd0, 32'd1);
  endtask

  typedef struct {
    int            id;
    int            len;
    bit            frz;
    logic [CW-1:0] res;
    bit            ab;
    bit            to;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{id: 0, len: 0,  frz: 1'b0, res: 4'd0,  ab: 1'b0, to: 1'b0};
    vecs[1] = '{id: 3, len: 15, frz: 1'b0, res: 4'd15, ab: 1'b0, to: 1'b0};
    vecs[2] = '{id: 1, len: 7,  frz: 1'b1, res: 4'd0,  ab: 1'b0, to: 1'b1};
    vecs[3] = '{id: 2, len: 3,  frz: 1'b0, res: 4'd3,  ab: 1'b0, to: 1'b0};
    vecs[4] = '{id: 1, len: 9,  frz: 1'b0, res: 4'd9,  ab: 1'b0, to: 1'b0};

    // Reset state.
    #12;
    check("rst_gnt",  32'(gnt), 32'd0);
    check("rst_flags", 32'({busy, done, aborted, timed_out}), 32'd0);
    check("rst_data", 32'({done_id, result}), 32'd0);
    check("rst_ctr",  32'({ctr_clr, ctr_start, ctr_stop}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single request with latency checks.
    set_len(2, 5);
    req[2] = 1'b1;
    push(2, 5, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_clr",      32'(ctr_clr), 32'd1);
    check("lat_clr_gnt",  32'(gnt), 32'b0100);
    check("lat_clr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_start",    32'({ctr_clr, ctr_start}), 32'b01);
    @(negedge clk);
    check("lat_run",      32'({ctr_start, ctr_stop}), 32'b00);
    wait_done(60);
    req[2] = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'({done, busy}), 32'b00);

    // Table of independent single-requester transactions.
    for (int v = 0; v < 5; v++) begin
      freeze = vecs[v].frz;
      set_len(vecs[v].id, vecs[v].len);
      req[vecs[v].id] = 1'b1;
      push(vecs[v].id, int'(vecs[v].res), vecs[v].ab, vecs[v].to);
      wait_done(80);
      req[vecs[v].id] = 1'b0;
      freeze = 1'b0;
      @(negedge clk);
      check("vec_idle", 32'({done, busy}), 32'b00);
    end

    // Abort: drop req[1] while the counter reads 4.
    set_len(1, 12);
    req[1] = 1'b1;
    push(1, 4, 1'b1, 1'b0);
    wait_count(1, 4, 40);
    req[1] = 1'b0;
    @(negedge clk);
    check("abort_stop", 32'(ctr_stop), 32'd1);
    wait_done(10);
    @(negedge clk);

    // Collision: drop in the same cycle the target is reached.
    set_len(3, 6);
    req[3] = 1'b1;
    push(3, 6, 1'b1, 1'b0);
    wait_count(3, 6, 40);
    req[3] = 1'b0;
    wait_done(10);
    @(negedge clk);

    // Reset in the middle of RUN.
    set_len(2, 10);
    req[2] = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_gnt",  32'(gnt), 32'd0);
    check("mid_rst_busy", 32'({busy, done}), 32'd0);
    check("mid_rst_ctr",  32'({ctr_clr, ctr_start, ctr_stop}), 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fairness with all requests held: order restarts at 0 after reset.
    for (int i = 0; i < N_REQ; i++) set_len(i, 3);
    req = '1;
    for (int k = 0; k < 5; k++) push(k % N_REQ, 3, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) wait_done(40);
    req = '0;
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("final_idle", 32'({busy, gnt}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
